// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle cpu_core: instruction field positions,
// opcode/aluop encodings, FSM states and overflow status codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam int OPC_LSB   = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  localparam logic [31:0] OVF_ADD  = 32'd1;
  localparam logic [31:0] OVF_ADDI = 32'd2;
  localparam logic [31:0] OVF_SUB  = 32'd3;

  function automatic logic [31:0] sext_imm(input logic [31:0] ins);
    return {{15{ins[16]}}, ins[16:0]};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub/and/or/sll/sra plus the compare flags used by
// the branch logic (flags are independent of the selected operation).
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        ovf,
  output logic        neq,
  output logic        lt
);

  logic [31:0] sum;
  logic [31:0] diff;

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    result = '0;
    ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum;
        ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a << shamt;
      ALU_SRA: result = $signed(a) >>> shamt;
      default: ;
    endcase
  end

  assign neq = (a != b);
  assign lt  = ($signed(a) < $signed(b));

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle core: FETCH -> DECODE -> EXEC -> {MEM} -> {WB}. Only PC and FSM
// state are held here; registers live in the external regfile, data in RAM.
module cpu_core
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        wren_reg;
  logic        we_reg;
  logic [4:0]  wreg_reg;
  logic [31:0] wdata_reg;
  logic [31:0] daddr_reg;
  logic [31:0] ddata_reg;

  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] imm_n, tgt, pc_inc, pc_branch;
  logic        is_rtype_alu;

  assign opcode       = q_imem[OPC_LSB +: 5];
  assign rd           = q_imem[RD_LSB +: 5];
  assign rs           = q_imem[RS_LSB +: 5];
  assign rt           = q_imem[RT_LSB +: 5];
  assign shamt        = q_imem[SHAMT_LSB +: 5];
  assign aluop        = q_imem[ALUOP_LSB +: 5];
  assign imm_n        = sext_imm(q_imem);
  assign tgt          = {5'd0, q_imem[26:0]};
  assign pc_inc       = pc_reg + 32'd1;
  assign pc_branch    = pc_reg + 32'd1 + imm_n;
  assign is_rtype_alu = (opcode == OP_RTYPE) && (aluop <= ALU_SRA);

  // Read indices are held at zero during FETCH so reset leaves every output at 0.
  always_comb begin
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    if (state_reg != S_FETCH) begin
      ctrl_readRegA = (opcode == OP_BEX) ? REG_STATUS : rs;
      case (opcode)
        OP_RTYPE:                     ctrl_readRegB = rt;
        OP_SW, OP_BNE, OP_BLT, OP_JR: ctrl_readRegB = rd;
        default: ;
      endcase
    end
  end

  logic [31:0] alu_b, alu_result;
  logic [4:0]  alu_op;
  logic        alu_ovf, alu_neq, alu_lt;

  assign alu_op = (opcode == OP_ADDI) ? ALU_ADD : aluop;
  assign alu_b  = (opcode == OP_ADDI) ? imm_n : data_readRegB;

  cpu_alu u_alu (
    .a      (data_readRegA),
    .b      (alu_b),
    .op     (alu_op),
    .shamt  (shamt),
    .result (alu_result),
    .ovf    (alu_ovf),
    .neq    (alu_neq),
    .lt     (alu_lt)
  );

  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_val;

  always_comb begin
    wb_valid = 1'b0;
    wb_reg   = rd;
    wb_val   = alu_result;
    if (is_rtype_alu || opcode == OP_ADDI) begin
      wb_valid = 1'b1;
      if (alu_ovf) begin
        wb_reg = REG_STATUS;
        wb_val = (opcode == OP_ADDI) ? OVF_ADDI : ((aluop == ALU_SUB) ? OVF_SUB : OVF_ADD);
      end
    end else if (opcode == OP_SETX) begin
      wb_valid = 1'b1;
      wb_reg   = REG_STATUS;
      wb_val   = tgt;
    end else if (opcode == OP_JAL) begin
      wb_valid = 1'b1;
      wb_reg   = REG_LINK;
      wb_val   = pc_inc;
    end
  end

  // ALU sees a = rs, b = rd for branches, so "rd < rs" is "a > b".
  logic [31:0] exec_pc;
  always_comb begin
    exec_pc = pc_inc;
    case (opcode)
      OP_J:   exec_pc = tgt;
      OP_BNE: if (alu_neq) exec_pc = pc_branch;
      OP_BLT: if (alu_neq && !alu_lt) exec_pc = pc_branch;
      OP_JR:  exec_pc = data_readRegB;
      OP_BEX: if (data_readRegA != 32'd0) exec_pc = tgt;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
      pc_reg    <= '0;
      wren_reg  <= 1'b0;
      we_reg    <= 1'b0;
      wreg_reg  <= '0;
      wdata_reg <= '0;
      daddr_reg <= '0;
      ddata_reg <= '0;
    end else begin
      wren_reg <= 1'b0;
      we_reg   <= 1'b0;
      case (state_reg)
        S_FETCH: state_reg <= S_DECODE;
        S_DECODE: begin
          daddr_reg <= data_readRegA + imm_n;
          ddata_reg <= data_readRegB;
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          if (wb_valid) begin
            we_reg    <= (wb_reg != 5'd0);
            wreg_reg  <= wb_reg;
            wdata_reg <= wb_val;
            state_reg <= S_WB;
          end else if (opcode == OP_SW) begin
            wren_reg  <= 1'b1;
            state_reg <= S_MEM;
          end else if (opcode == OP_LW) begin
            state_reg <= S_MEM;
          end else begin
            pc_reg    <= exec_pc;
            state_reg <= S_FETCH;
          end
        end
        S_MEM: begin
          if (opcode == OP_LW) begin
            we_reg    <= (rd != 5'd0);
            wreg_reg  <= rd;
            state_reg <= S_WB;
          end else begin
            pc_reg    <= pc_inc;
            state_reg <= S_FETCH;
          end
        end
        S_WB: begin
          pc_reg    <= (opcode == OP_JAL) ? tgt : pc_inc;
          state_reg <= S_FETCH;
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign address_imem     = pc_reg;
  assign wren             = wren_reg;
  assign ctrl_writeEnable = we_reg;
  assign ctrl_writeReg    = wreg_reg;
  // Load data only arrives from the RAM during WB, so it bypasses the register.
  assign data_writeReg    = (state_reg == S_WB && opcode == OP_LW) ? q_dmem : wdata_reg;
  assign address_dmem     = daddr_reg;
  assign data             = ddata_reg;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: ROM/RAM/regfile environment plus an instruction-level ISA
// model that predicts per-instruction cycle counts, write strobes and values.
module tb_cpu_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_imem, q_imem = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem = '0;

  cpu_core dut (
    .clock            (clock),
    .reset            (reset),
    .address_imem     (address_imem),
    .q_imem           (q_imem),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .wren             (wren),
    .address_dmem     (address_dmem),
    .data             (data),
    .q_dmem           (q_dmem)
  );

  always #5 clock = ~clock;

  logic [31:0] rom [4096];
  logic [31:0] ram [4096] = '{default: 32'd0};
  logic [31:0] rf  [32]   = '{default: 32'd0};

  always @(posedge clock) q_imem <= rom[address_imem[11:0]];
  always @(posedge clock) begin
    q_dmem <= ram[address_dmem[11:0]];
    if (wren) ram[address_dmem[11:0]] <= data;
  end
  always @(posedge clock)
    if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];

  localparam int OP_J = 1, OP_BNE = 2, OP_JAL = 3, OP_JR = 4, OP_ADDI = 5, OP_BLT = 6;
  localparam int OP_SW = 7, OP_LW = 8, OP_SETX = 21, OP_BEX = 22;
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;
  localparam int RAND_N = 40;
  localparam int END_PC = 24 + RAND_N;

  logic [31:0] m_reg [32]   = '{default: 32'd0};
  logic [31:0] m_mem [4096] = '{default: 32'd0};
  logic [31:0] m_pc = '0;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] enc_r(input int aop, input int rd, input int rs, input int rt, input int sh);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(aop), 2'b00};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
    return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction
  function automatic logic [31:0] enc_t(input int op, input int t);
    return {5'(op), 27'(t)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s pc=%0d observed=%h expected=%h", tag, m_pc, obs, exp);
    end
  endtask

  // Model one instruction from the ISA rules, then watch the DUT for its cycles.
  task automatic run_instr();
    logic [31:0] ins, va, vb, vrd, n, t, wval, maddr, mdata, nxt;
    logic [4:0]  op, rd, rs, rt, sh, aop, wreg;
    int cyc;
    bit has_w, is_sw;
    longint s;
    ins = rom[m_pc[11:0]];
    op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
    sh = ins[11:7];  aop = ins[6:2];
    n = {{15{ins[16]}}, ins[16:0]};
    t = {5'd0, ins[26:0]};
    va = m_reg[rs]; vb = m_reg[rt]; vrd = m_reg[rd];
    cyc = 3; has_w = 0; is_sw = 0; wreg = rd; wval = '0;
    maddr = va + n; mdata = vrd; nxt = m_pc + 1;
    case (int'(op))
      0: if (aop <= 5'd5) begin
        cyc = 4; has_w = 1;
        case (aop)
          5'd0: begin
            wval = va + vb; s = longint'($signed(va)) + longint'($signed(vb));
            if (s > S_MAX || s < S_MIN) begin wreg = 5'd30; wval = 32'd1; end
          end
          5'd1: begin
            wval = va - vb; s = longint'($signed(va)) - longint'($signed(vb));
            if (s > S_MAX || s < S_MIN) begin wreg = 5'd30; wval = 32'd3; end
          end
          5'd2: wval = va & vb;
          5'd3: wval = va | vb;
          5'd4: wval = va << sh;
          default: wval = $signed(va) >>> sh;
        endcase
      end
      OP_ADDI: begin
        cyc = 4; has_w = 1; wval = va + n;
        s = longint'($signed(va)) + longint'($signed(n));
        if (s > S_MAX || s < S_MIN) begin wreg = 5'd30; wval = 32'd2; end
      end
      OP_SW:   begin cyc = 4; is_sw = 1; end
      OP_LW:   begin cyc = 5; has_w = 1; wval = m_mem[maddr[11:0]]; end
      OP_J:    nxt = t;
      OP_BNE:  if (vrd != va) nxt = m_pc + 1 + n;
      OP_BLT:  if ($signed(vrd) < $signed(va)) nxt = m_pc + 1 + n;
      OP_JAL:  begin cyc = 4; has_w = 1; wreg = 5'd31; wval = m_pc + 1; nxt = t; end
      OP_JR:   nxt = vrd;
      OP_BEX:  if (m_reg[30] != 0) nxt = t;
      OP_SETX: begin cyc = 4; has_w = 1; wreg = 5'd30; wval = t; end
      default: ;
    endcase
    if (wreg == 5'd0) has_w = 0;
    for (int c = 1; c <= cyc; c++) begin
      @(negedge clock);
      if (c == 1) chk("fetch_pc", address_imem, m_pc);
      chk("reg_we", {31'd0, ctrl_writeEnable}, {31'd0, has_w && c == cyc});
      chk("ram_wren", {31'd0, wren}, {31'd0, is_sw && c == cyc});
      if (has_w && c == cyc) begin
        chk("wb_reg", {27'd0, ctrl_writeReg}, {27'd0, wreg});
        chk("wb_data", data_writeReg, wval);
      end
      if (is_sw && c == cyc) begin
        chk("sw_addr", address_dmem, maddr);
        chk("sw_data", data, mdata);
      end
    end
    if (has_w) m_reg[wreg] = wval;
    if (is_sw) m_mem[maddr[11:0]] = mdata;
    m_pc = nxt;
  endtask

  initial begin
    int steps;
    bit done;
    for (int i = 0; i < 4096; i++) rom[i] = 32'd0;
    rom[0]   = enc_i(OP_ADDI, 1, 0, 5);
    rom[1]   = enc_i(OP_ADDI, 2, 0, 7);
    rom[2]   = enc_r(0, 3, 1, 2, 0);
    rom[3]   = enc_i(OP_SW, 3, 0, 4);
    rom[4]   = enc_i(OP_LW, 5, 0, 4);
    rom[5]   = enc_i(OP_BNE, 1, 2, 1);
    rom[6]   = enc_i(OP_ADDI, 6, 0, 99);
    rom[7]   = enc_i(OP_BLT, 1, 2, 1);
    rom[8]   = enc_i(OP_ADDI, 6, 0, 98);
    rom[9]   = enc_t(OP_JAL, 100);
    rom[10]  = enc_t(OP_SETX, 3);
    rom[11]  = enc_t(OP_BEX, 13);
    rom[12]  = enc_i(OP_ADDI, 6, 0, 97);
    rom[13]  = enc_t(OP_SETX, 0);
    rom[14]  = enc_t(OP_BEX, 200);
    rom[15]  = enc_i(OP_ADDI, 1, 0, 1);
    rom[16]  = enc_r(4, 1, 1, 0, 31);
    rom[17]  = enc_i(OP_ADDI, 1, 1, -1);
    rom[18]  = enc_r(0, 4, 1, 1, 0);
    rom[19]  = enc_i(OP_ADDI, 10, 0, -1);
    rom[20]  = enc_r(1, 7, 1, 10, 0);
    rom[21]  = enc_i(OP_ADDI, 11, 1, 1);
    rom[22]  = enc_i(OP_ADDI, 0, 0, 9);
    rom[23]  = enc_i(OP_BNE, 2, 2, 5);
    rom[100] = enc_i(OP_ADDI, 12, 0, -3);
    rom[101] = enc_i(OP_JR, 31, 0, 0);
    for (int i = 0; i < RAND_N; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind <= 3)
        rom[24 + i] = enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                            int'($urandom_range(0, 31)));
      else if (kind <= 5)
        rom[24 + i] = enc_i(OP_ADDI, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                            int'($urandom_range(0, 131071)));
      else if (kind <= 7)
        rom[24 + i] = enc_i((kind == 6) ? OP_SW : OP_LW, int'($urandom_range(0, 31)),
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 63)));
      else if (kind == 8)
        rom[24 + i] = enc_t(OP_SETX, int'($urandom_range(0, 134217727)));
      else
        rom[24 + i] = enc_t(31, int'($urandom_range(0, 134217727)));
    end
    rom[END_PC] = enc_t(OP_J, END_PC);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_pc", address_imem, 32'd0);
    chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rst_wren", {31'd0, wren}, 32'd0);
    chk("rst_wreg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("rst_wdata", data_writeReg, 32'd0);
    chk("rst_daddr", address_dmem, 32'd0);
    chk("rst_ddata", data, 32'd0);
    chk("rst_rega", {27'd0, ctrl_readRegA}, 32'd0);
    reset = 1'b1;

    // Partial run, then reset lands in the MEM cycle of the sw at address 3.
    repeat (3) run_instr();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (c == 1) chk("sw_fetch", address_imem, m_pc);
      chk("sw_wren_early", {31'd0, wren}, 32'd0);
    end
    @(negedge clock);
    chk("sw_wren_mem", {31'd0, wren}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_pc", address_imem, 32'd0);
    chk("abort_wren", {31'd0, wren}, 32'd0);
    chk("abort_we", {31'd0, ctrl_writeEnable}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("abort_ram", ram[4], m_mem[4]);
    reset = 1'b1;
    m_pc = 32'd0;

    steps = 0;
    done = 0;
    while (!done && steps < 400) begin
      done = (m_pc == END_PC);
      run_instr();
      steps++;
    end
    chk("reached_end", m_pc, END_PC);
    for (int i = 0; i < 32; i++) chk("final_reg", rf[i], m_reg[i]);
    chk("final_ram4", ram[4], m_mem[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
